// File: rtl/sysid_regs_pkg.sv
// Shared constants for the system-identification register file.
// Word addresses, CAPS layout and CTRL bit positions.
package sysid_regs_pkg;

   localparam logic [7:0] ADDR_ID      = 8'd0;
   localparam logic [7:0] ADDR_TS      = 8'd1;
   localparam logic [7:0] ADDR_CAPS    = 8'd2;
   localparam logic [7:0] ADDR_SCRATCH = 8'd3;
   localparam logic [7:0] ADDR_UP_LO   = 8'd4;
   localparam logic [7:0] ADDR_UP_HI   = 8'd5;
   localparam logic [7:0] ADDR_CTRL    = 8'd6;

   localparam logic [7:0] CAPS_VERSION = 8'h01;

   localparam int CTRL_CLEAR  = 0;
   localparam int CTRL_FREEZE = 1;

   function automatic logic [31:0] caps_word(input int aw, input int uw);
      return {CAPS_VERSION, 8'(aw), 16'(uw)};
   endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with clear/freeze and a snapshot
// of the upper half taken when the low word is read.
module sysid_uptime_counter
   import sysid_regs_pkg::*;
#(
   parameter int UPTIME_WIDTH = 64
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    freeze,
   input  logic                    snap,
   output logic [UPTIME_WIDTH-1:0] count,
   output logic [31:0]             hi_shadow
);

   logic [UPTIME_WIDTH-1:0] count_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (!freeze) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

   // snap sees the pre-increment value so LO and HI form one sample
   if (UPTIME_WIDTH > 32) begin : g_hi
      logic [UPTIME_WIDTH-33:0] shadow_q;

      always_ff @(posedge clock) begin
         if (!reset_n) begin
            shadow_q <= '0;
         end else if (snap) begin
            shadow_q <= count_q[UPTIME_WIDTH-1:32];
         end
      end

      assign hi_shadow = 32'(shadow_q);
   end else begin : g_no_hi
      logic unused_snap;
      assign unused_snap = snap;
      assign hi_shadow   = '0;
   end

endmodule

// File: rtl/sysid_regs.sv
// System-identification register file on an Avalon-MM slave port
// with one-cycle registered reads.
module sysid_regs
   import sysid_regs_pkg::*;
#(
   parameter logic [31:0] ID_VALUE      = 32'd12345678,
   parameter logic [31:0] TIMESTAMP     = 32'd1431967266,
   parameter int          ADDR_WIDTH    = 3,
   parameter int          UPTIME_WIDTH  = 64,
   parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read,
   input  logic                  write,
   input  logic [31:0]           writedata,
   input  logic [3:0]            byteenable,
   output logic [31:0]           readdata,
   output logic                  readdatavalid
);

   localparam logic [31:0] CAPS = caps_word(ADDR_WIDTH, UPTIME_WIDTH);

   logic [7:0]  word;
   logic        rd_acc;
   logic        hit_id;
   logic        hit_ts;
   logic        hit_caps;
   logic        hit_scr;
   logic        hit_lo;
   logic        hit_hi;
   logic        hit_ctrl;
   logic        ctrl_wr;
   logic        clear;
   logic        snap;
   logic [31:0] scratch_q;
   logic        freeze_q;
   logic [31:0] rd_mux;
   logic [31:0] hi_shadow;
   logic [UPTIME_WIDTH-1:0] count;
   logic        unused_cnt;

   assign word     = 8'(address);
   assign hit_id   = (word == ADDR_ID);
   assign hit_ts   = (word == ADDR_TS);
   assign hit_caps = (word == ADDR_CAPS);
   assign hit_scr  = (word == ADDR_SCRATCH);
   assign hit_lo   = (word == ADDR_UP_LO);
   assign hit_hi   = (word == ADDR_UP_HI);
   assign hit_ctrl = (word == ADDR_CTRL);

   // a simultaneous write wins; the read is dropped
   assign rd_acc  = read & ~write;
   assign ctrl_wr = write & hit_ctrl & byteenable[0];
   assign clear   = ctrl_wr & writedata[CTRL_CLEAR];
   assign snap    = rd_acc & hit_lo;

   sysid_uptime_counter #(
      .UPTIME_WIDTH (UPTIME_WIDTH)
   ) u_uptime (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (clear),
      .freeze    (freeze_q),
      .snap      (snap),
      .count     (count),
      .hi_shadow (hi_shadow)
   );

   assign unused_cnt = ^count;

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         hit_id:   rd_mux = ID_VALUE;
         hit_ts:   rd_mux = TIMESTAMP;
         hit_caps: rd_mux = CAPS;
         hit_scr:  rd_mux = scratch_q;
         hit_lo:   rd_mux = count[31:0];
         hit_hi:   rd_mux = hi_shadow;
         hit_ctrl: rd_mux = {30'd0, freeze_q, 1'b0};
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         scratch_q     <= SCRATCH_RESET;
         freeze_q      <= 1'b0;
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         if (write && hit_scr) begin
            for (int i = 0; i < 4; i++) begin
               if (byteenable[i]) begin
                  scratch_q[8*i +: 8] <= writedata[8*i +: 8];
               end
            end
         end
         if (ctrl_wr) begin
            freeze_q <= writedata[CTRL_FREEZE];
         end
         readdatavalid <= rd_acc;
         if (rd_acc) begin
            readdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_sysid_regs.sv
// Randomised scoreboard bench for sysid_regs against a
// behavioural model of the register map and uptime counter.
module tb_sysid_regs;

   localparam logic [31:0] ID_V  = 32'd12345678;
   localparam logic [31:0] TS_V  = 32'd1431967266;
   localparam logic [31:0] SCR_R = 32'h0;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] readdata;
   logic        readdatavalid;

   always #5 clock = ~clock;

   sysid_regs #(
      .ID_VALUE      (ID_V),
      .TIMESTAMP     (TS_V),
      .ADDR_WIDTH    (3),
      .UPTIME_WIDTH  (64),
      .SCRATCH_RESET (SCR_R)
   ) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   typedef struct {
      logic [31:0] data;
      int          tag;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // reference state, always the value holding before the next edge
   logic [63:0] m_cnt = '0;
   logic [31:0] m_shadow = '0;
   logic [31:0] m_scratch = SCR_R;
   logic        m_freeze = 1'b0;

   function automatic logic [31:0] ref_read(input logic [2:0] a);
      case (a)
         3'd0: return ID_V;
         3'd1: return TS_V;
         3'd2: return {8'h01, 8'd3, 16'd64};
         3'd3: return m_scratch;
         3'd4: return m_cnt[31:0];
         3'd5: return m_shadow;
         3'd6: return {30'd0, m_freeze, 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic step(input logic rn, input logic r, input logic w,
                       input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] be, input string nm);
      logic clr;
      logic nfrz;
      @(negedge clock);
      reset_n = rn; read = r; write = w;
      address = a; writedata = d; byteenable = be;
      if (!rn) begin
         m_cnt = '0; m_shadow = '0; m_scratch = SCR_R; m_freeze = 1'b0;
      end else begin
         clr  = 1'b0;
         nfrz = m_freeze;
         if (r && !w) begin
            q.push_back('{ref_read(a), cyc, nm});
            if (a == 3'd4) m_shadow = m_cnt[63:32];
         end
         if (w && a == 3'd3) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
         end
         if (w && a == 3'd6 && be[0]) begin
            clr  = d[0];
            nfrz = d[1];
         end
         if (clr) m_cnt = '0;
         else if (!m_freeze) m_cnt = m_cnt + 64'd1;
         m_freeze = nfrz;
      end
   endtask

   task automatic rd(input logic [2:0] a, input string nm);
      step(1'b1, 1'b1, 1'b0, a, $urandom, 4'h0, nm);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      step(1'b1, 1'b0, 1'b1, a, d, be, "wr");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, "idle");
   endtask

   // monitor: every valid must match the oldest expectation, one edge late
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (readdatavalid) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_valid: got data %h with none outstanding", readdata);
            end else begin
               e = q.pop_front();
               if (readdata !== e.data || e.tag != cyc - 1) begin
                  n_bad++;
                  $display("FAIL %s: got %h at edge %0d required %h at edge %0d",
                           e.name, readdata, cyc - 1, e.data, e.tag);
               end
            end
         end else if (q.size() > 0 && q[0].tag <= cyc - 1) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no readdatavalid required %h", e.name, e.data);
         end
      end
   end

   initial begin
      logic r, w;
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, "rst");
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, "rst");
      @(posedge clock); #2;
      check("reset_readdata", readdata, 32'd0);
      check("reset_valid", 32'(readdatavalid), 32'd0);

      rd(3'd0, "id");
      rd(3'd1, "timestamp");
      rd(3'd2, "caps");
      idle(2);

      wr(3'd3, 32'hDEADBEEF, 4'hF);
      wr(3'd3, 32'h00000011, 4'b0001);
      rd(3'd3, "scratch_bytelane");
      wr(3'd0, 32'h0BADF00D, 4'hF);
      rd(3'd0, "id_after_write");

      wr(3'd6, 32'h2, 4'h1);
      idle(1);
      force u_dut.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
      #1 release u_dut.u_uptime.count_q;
      m_cnt = 64'h0000_0000_FFFF_FFFF;
      wr(3'd6, 32'h0, 4'h1);
      rd(3'd4, "uptime_lo_carry");
      rd(3'd5, "uptime_hi_shadow");
      idle(3);
      rd(3'd5, "uptime_hi_no_resnap");

      wr(3'd6, 32'h2, 4'h1);
      rd(3'd4, "frozen_a");
      idle(10);
      rd(3'd4, "frozen_b");
      rd(3'd6, "ctrl_readback");
      wr(3'd6, 32'h3, 4'h1);
      rd(3'd4, "clear_frozen_a");
      idle(4);
      rd(3'd4, "clear_frozen_b");
      wr(3'd6, 32'h0, 4'h1);
      idle(2);
      rd(3'd4, "unfrozen");
      wr(3'd6, 32'h3, 4'hE);
      rd(3'd6, "ctrl_be0_off");

      step(1'b1, 1'b1, 1'b1, 3'd3, 32'h5, 4'hF, "rw_same");
      rd(3'd3, "scratch_after_rw");
      rd(3'd7, "unmapped");

      rd(3'd4, "pre_reset_rd");
      step(1'b0, 1'b1, 1'b0, 3'd3, 32'd0, 4'h0, "rst_inflight");
      @(posedge clock); #2;
      check("reset_drops_valid", 32'(readdatavalid), 32'd0);
      check("reset_clears_data", readdata, 32'd0);
      idle(2);
      rd(3'd4, "uptime_after_release");
      rd(3'd3, "scratch_after_reset");

      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 2) != 0);
         w = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0)
            step(1'b0, r, w, 3'($urandom), $urandom, 4'($urandom), "rand_rst");
         else
            step(1'b1, r, w, 3'($urandom), $urandom, 4'($urandom), "rand_rd");
      end

      idle(4);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
